// File: rtl/opl3_host_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the OPL3 host write port.
// Each grant is issued as an address-phase write then a data-phase write, each followed by a recovery gap.
module opl3_host_bus_arbiter #(
    parameter int unsigned WR_PULSE_CYCLES      = 4,
    parameter int unsigned ADDR_RECOVERY_CYCLES = 8,
    parameter int unsigned DATA_RECOVERY_CYCLES = 32
) (
    input  logic            clk_host,
    input  logic            ic_n,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_bank,
    input  logic [1:0][7:0] req_reg,
    input  logic [1:0][7:0] req_data,
    output logic [1:0]      req_ready,
    output logic            cs_n,
    output logic            wr_n,
    output logic            rd_n,
    output logic [1:0]      address,
    output logic [7:0]      din,
    output logic            busy,
    output logic            grant_id
);

    localparam int unsigned MAX_AB  = (WR_PULSE_CYCLES > ADDR_RECOVERY_CYCLES) ?
                                      WR_PULSE_CYCLES : ADDR_RECOVERY_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > DATA_RECOVERY_CYCLES) ? MAX_AB : DATA_RECOVERY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AREC_LD  = CNT_W'(ADDR_RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0] DREC_LD  = CNT_W'(DATA_RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_WR,
        S_A_REC,
        S_D_WR,
        S_D_REC
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             bank_q;
    logic [7:0]       data_q;
    logic             win;
    logic             xfer;

    assign rd_n = 1'b1;

    // Round-robin winner; a tie goes to the requester that was not served last.
    always_comb begin
        win       = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
        if (ic_n && (state_q == S_IDLE) && (req_valid != 2'b00)) begin
            req_ready[win] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk_host) begin
        if (!ic_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            bank_q   <= 1'b0;
            data_q   <= 8'h00;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            address  <= 2'b00;
            din      <= 8'h00;
            busy     <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        state_q  <= S_A_WR;
                        cnt_q    <= PULSE_LD;
                        last_q   <= win;
                        grant_id <= win;
                        bank_q   <= req_bank[win];
                        data_q   <= req_data[win];
                        cs_n     <= 1'b0;
                        wr_n     <= 1'b0;
                        address  <= {req_bank[win], 1'b0};
                        din      <= req_reg[win];
                        busy     <= 1'b1;
                    end
                end
                S_A_WR: begin
                    if (cnt_q == '0) begin
                        state_q <= S_A_REC;
                        cnt_q   <= AREC_LD;
                        cs_n    <= 1'b1;
                        wr_n    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_A_REC: begin
                    // address/din only move on the cycle cs_n falls
                    if (cnt_q == '0) begin
                        state_q <= S_D_WR;
                        cnt_q   <= PULSE_LD;
                        cs_n    <= 1'b0;
                        wr_n    <= 1'b0;
                        address <= {bank_q, 1'b1};
                        din     <= data_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_D_WR: begin
                    if (cnt_q == '0) begin
                        state_q <= S_D_REC;
                        cnt_q   <= DREC_LD;
                        cs_n    <= 1'b1;
                        wr_n    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_D_REC: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_n    <= 1'b1;
                    wr_n    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opl3_host_bus_arbiter.sv
// Directed bench for opl3_host_bus_arbiter: default timing instance plus a 1/1/1 corner instance.
module tb_opl3_host_bus_arbiter;

    logic            clk = 1'b0;
    logic            ic_n;
    logic [1:0]      valid;
    logic [1:0]      bank;
    logic [1:0][7:0] rg;
    logic [1:0][7:0] dat;
    logic [1:0]      ready;
    logic            cs_n, wr_n, rd_n, busy, gid;
    logic [1:0]      address;
    logic [7:0]      din;

    logic [1:0]      valid_c;
    logic [1:0]      bank_c;
    logic [1:0][7:0] rg_c;
    logic [1:0][7:0] dat_c;
    logic [1:0]      ready_c;
    logic            cs_c, wr_c, rd_c, busy_c, gid_c;
    logic [1:0]      addr_c;
    logic [7:0]      din_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    opl3_host_bus_arbiter u_dut (
        .clk_host(clk), .ic_n(ic_n), .req_valid(valid), .req_bank(bank),
        .req_reg(rg), .req_data(dat), .req_ready(ready), .cs_n(cs_n),
        .wr_n(wr_n), .rd_n(rd_n), .address(address), .din(din),
        .busy(busy), .grant_id(gid)
    );

    opl3_host_bus_arbiter #(
        .WR_PULSE_CYCLES(1), .ADDR_RECOVERY_CYCLES(1), .DATA_RECOVERY_CYCLES(1)
    ) u_dut_c (
        .clk_host(clk), .ic_n(ic_n), .req_valid(valid_c), .req_bank(bank_c),
        .req_reg(rg_c), .req_data(dat_c), .req_ready(ready_c), .cs_n(cs_c),
        .wr_n(wr_c), .rd_n(rd_c), .address(addr_c), .din(din_c),
        .busy(busy_c), .grant_id(gid_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ic_n    = 1'b0;
        valid   = 2'b01;
        valid_c = 2'b01;
        bank = 2'b00; rg = '0; dat = '0;
        bank_c = 2'b00; rg_c = '0; dat_c = '0;
        tick();
        tick();
        checks++;
        if ({cs_n, wr_n, rd_n, address, din, busy, gid} !== {3'b111, 2'b00, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_pins: got %b required %b",
                     {cs_n, wr_n, rd_n, address, din, busy, gid}, {3'b111, 2'b00, 8'h00, 2'b00});
        end
        checks++;
        if (ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b required 00", ready);
        end
        checks++;
        if ({cs_c, wr_c, rd_c, addr_c, din_c, busy_c, gid_c, ready_c} !== {3'b111, 2'b00, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_corner: got %b", {cs_c, wr_c, rd_c, addr_c, din_c, busy_c, gid_c, ready_c});
        end
        valid   = 2'b00;
        valid_c = 2'b00;
        ic_n    = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic       e_cs;
        logic [1:0] e_addr;
        logic [7:0] e_din;
        logic       e_busy;
        valid = 2'b01; bank[0] = 1'b1; rg[0] = 8'h05; dat[0] = 8'h01;
        #1;
        checks++;
        if (ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b required 01", ready);
        end
        tick();
        valid = 2'b00;
        checks++;
        if (gid !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got %b required 0", gid);
        end
        for (int k = 1; k <= 49; k++) begin
            e_cs   = !((k <= 4) || (k >= 13 && k <= 16));
            e_addr = (k <= 12) ? 2'b10 : 2'b11;
            e_din  = (k <= 12) ? 8'h05 : 8'h01;
            e_busy = (k <= 48);
            checks++;
            if ({cs_n, wr_n, address, din, busy} !== {e_cs, e_cs, e_addr, e_din, e_busy}) begin
                errors++;
                $display("FAIL single_T+%0d: got cs=%b wr=%b addr=%b din=%h busy=%b required cs=%b addr=%b din=%h busy=%b",
                         k, cs_n, wr_n, address, din, busy, e_cs, e_addr, e_din, e_busy);
            end
            if (k < 49) tick();
        end
    endtask

    task automatic test_tie();
        int e;
        ic_n  = 1'b0;
        valid = 2'b11;
        bank  = 2'b10;
        rg[0] = 8'h10; rg[1] = 8'h21;
        dat[0] = 8'hA0; dat[1] = 8'hB1;
        tick();
        checks++;
        if (ready !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_reset_wins: ready=%b busy=%b required 00 0", ready, busy);
        end
        ic_n = 1'b1;
        #1;
        checks++;
        if (ready !== 2'b01) begin
            errors++;
            $display("FAIL tie_first: got %b required 01", ready);
        end
        for (int i = 0; i < 4; i++) begin
            e = i % 2;
            tick();
            checks++;
            if ({gid, cs_n, address, din} !== {e[0], 1'b0, bank[e], 1'b0, rg[e]}) begin
                errors++;
                $display("FAIL tie_addr_%0d: got gid=%b cs=%b addr=%b din=%h required gid=%0d", i, gid, cs_n, address, din, e);
            end
            repeat (12) tick();
            checks++;
            if ({cs_n, address, din} !== {1'b0, bank[e], 1'b1, dat[e]}) begin
                errors++;
                $display("FAIL tie_data_%0d: got cs=%b addr=%b din=%h required data %h", i, cs_n, address, din, dat[e]);
            end
            if (i == 3) valid = 2'b00;
            repeat (36) tick();
            checks++;
            if (busy !== 1'b0 || ready !== ((i == 3) ? 2'b00 : ((e == 0) ? 2'b10 : 2'b01))) begin
                errors++;
                $display("FAIL tie_next_%0d: busy=%b ready=%b", i, busy, ready);
            end
        end
    endtask

    task automatic test_lone();
        int cnt;
        valid = 2'b10; bank[1] = 1'b1; rg[1] = 8'h7E; dat[1] = 8'h3C;
        #1;
        checks++;
        if (ready !== 2'b10) begin
            errors++;
            $display("FAIL lone_ready: got %b required 10", ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) valid = 2'b00;
            checks++;
            if ({gid, cs_n, address, din} !== {1'b1, 1'b0, 2'b10, 8'h7E}) begin
                errors++;
                $display("FAIL lone_grant_%0d: gid=%b cs=%b addr=%b din=%h", i, gid, cs_n, address, din);
            end
            cnt = 1;
            if (i < 2) begin
                while (ready !== 2'b10 && cnt < 100) begin tick(); cnt++; end
            end else begin
                while (busy !== 1'b0 && cnt < 100) begin tick(); cnt++; end
            end
            // 48 busy cycles between acceptances -> next accept at T+49
            checks++;
            if (cnt != 49) begin
                errors++;
                $display("FAIL lone_spacing_%0d: got %0d cycles required 49", i, cnt);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int cnt;
        valid = 2'b01; bank[0] = 1'b0; rg[0] = 8'h33; dat[0] = 8'h44;
        #1;
        checks++;
        if (ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_ready: got %b required 01", ready);
        end
        tick();
        valid = 2'b00;
        repeat (13) tick();
        checks++;
        if ({cs_n, wr_n, address, din} !== {2'b00, 2'b01, 8'h44}) begin
            errors++;
            $display("FAIL midrst_dwr: cs=%b wr=%b addr=%b din=%h required 0 0 01 44", cs_n, wr_n, address, din);
        end
        ic_n = 1'b0;
        tick();
        checks++;
        if ({cs_n, wr_n, rd_n, address, din, busy, gid, ready} !== {3'b111, 2'b00, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL midrst_pins: got %b", {cs_n, wr_n, rd_n, address, din, busy, gid, ready});
        end
        ic_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++;
            $display("FAIL midrst_no_resume: busy=%b cs=%b required 0 1", busy, cs_n);
        end
        valid = 2'b10; bank[1] = 1'b1; rg[1] = 8'h55; dat[1] = 8'h66;
        #1;
        checks++;
        if (ready !== 2'b10) begin
            errors++;
            $display("FAIL midrst_new_ready: got %b required 10", ready);
        end
        tick();
        valid = 2'b00;
        checks++;
        if ({cs_n, wr_n, address, din, gid, busy} !== {2'b00, 2'b10, 8'h55, 2'b11}) begin
            errors++;
            $display("FAIL midrst_fresh_awr: cs=%b wr=%b addr=%b din=%h gid=%b busy=%b", cs_n, wr_n, address, din, gid, busy);
        end
        cnt = 1;
        while (busy !== 1'b0 && cnt < 100) begin tick(); cnt++; end
        checks++;
        if (cnt != 49) begin
            errors++;
            $display("FAIL midrst_drain: got %0d cycles required 49", cnt);
        end
    endtask

    task automatic test_valid_withdrawn();
        int lows;
        int saw0;
        valid = 2'b10;
        #1;
        checks++;
        if (ready !== 2'b10) begin
            errors++;
            $display("FAIL withdrawn_start: got %b required 10", ready);
        end
        tick();
        valid = 2'b00;
        repeat (4) tick();
        valid = 2'b01;
        #1;
        checks++;
        if (ready !== 2'b00) begin
            errors++;
            $display("FAIL withdrawn_pulse_ready: got %b required 00", ready);
        end
        tick();
        valid = 2'b00;
        lows = 0;
        saw0 = 0;
        for (int k = 0; k < 55; k++) begin
            if (cs_n === 1'b0) lows++;
            if (ready[0] === 1'b1) saw0++;
            tick();
        end
        checks++;
        if (lows != 4 || saw0 != 0 || busy !== 1'b0 || gid !== 1'b1) begin
            errors++;
            $display("FAIL withdrawn_quiet: cs_low=%0d ready0=%0d busy=%b gid=%b required 4 0 0 1", lows, saw0, busy, gid);
        end
    endtask

    task automatic test_param_corner();
        logic [12:0] e;
        valid_c = 2'b01; bank_c[0] = 1'b1; rg_c[0] = 8'h9A; dat_c[0] = 8'hC3;
        #1;
        checks++;
        if (ready_c !== 2'b01) begin
            errors++;
            $display("FAIL corner_ready: got %b required 01", ready_c);
        end
        tick();
        valid_c = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            case (k)
                1:       e = {2'b00, 2'b10, 8'h9A, 1'b1};
                2:       e = {2'b11, 2'b10, 8'h9A, 1'b1};
                3:       e = {2'b00, 2'b11, 8'hC3, 1'b1};
                4:       e = {2'b11, 2'b11, 8'hC3, 1'b1};
                default: e = {2'b11, 2'b11, 8'hC3, 1'b0};
            endcase
            checks++;
            if ({cs_c, wr_c, addr_c, din_c, busy_c} !== e) begin
                errors++;
                $display("FAIL corner_T+%0d: got %b required %b", k, {cs_c, wr_c, addr_c, din_c, busy_c}, e);
            end
            if (k < 5) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_lone();
        test_reset_mid_write();
        test_valid_withdrawn();
        test_param_corner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
